// File: rtl/ib_vnu_v2c_src_ctrl_pkg.sv
// Shared definitions for the degree-3 VNU iteration/layer sequencer and the
// CNU-side controller: state encoding, default geometry and a width helper.
package ib_vnu_v2c_src_ctrl_pkg;

    // Default datapath geometry; QUAN_SIZE and PIPELINE_DEPTH match the
    // decoder-wide defines so the controller and datapath agree on drain length.
    localparam int IB_QUAN_SIZE      = 4;
    localparam int IB_PIPELINE_DEPTH = 3;
    localparam int IB_ITER_MAX       = 10;
    localparam int IB_LAYER_NUM      = 4;
    localparam int IB_ITER_WIDTH     = 4;
    localparam int IB_LAYER_WIDTH    = 2;

    // Sequencer states, 3-bit encoding fixed so traces are comparable
    // between the VNU-side and CNU-side controllers.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FIRST_ITER = 3'd1,
        ST_ITER       = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_DONE       = 3'd4
    } ib_ctrl_state_t;

    // Width of the drain down-counter: it must hold PIPELINE_DEPTH-2,
    // which always fits in clog2(PIPELINE_DEPTH) bits; never narrower than 1.
    function automatic int ib_drain_width(input int depth);
        int w;
        w = $clog2(depth);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ib_vnu_v2c_src_ctrl_drain_counter.sv
// ib_drain_counter: loadable down-counter with a zero flag. Load has priority
// over decrement; decrement saturates at zero so the flag stays asserted.
// Shared between the VNU-side and CNU-side pipeline drain sequencing.
module ib_drain_counter #(
    parameter int CNT_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Count register: load, else decrement while nonzero
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/ib_vnu_v2c_src_ctrl.sv
// ib_vnu_v2c_src_ctrl: iteration/layer sequencer in front of the degree-3 VNU.
// Selects channel-LLR bypass during iteration 0, gates the c2v pipeline and the
// decision-node capture, drains the pipeline after the last layer and pulses done.
// Optional early termination on syndrome convergence: define IB_EARLY_TERM_EN.
module ib_vnu_v2c_src_ctrl
    import ib_vnu_v2c_src_ctrl_pkg::*;
#(
    parameter int ITER_MAX       = IB_ITER_MAX,
    parameter int LAYER_NUM      = IB_LAYER_NUM,
    parameter int PIPELINE_DEPTH = IB_PIPELINE_DEPTH,
    parameter int ITER_WIDTH     = IB_ITER_WIDTH,
    parameter int LAYER_WIDTH    = IB_LAYER_WIDTH
) (
    input  logic                   read_clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   layer_done,
    input  logic                   converged,
    output logic                   v2c_src,
    output logic                   pipe_en,
    output logic                   dec_en,
    output logic [ITER_WIDTH-1:0]  iter_cnt,
    output logic [LAYER_WIDTH-1:0] layer_cnt,
    output logic                   busy,
    output logic                   done
);

    localparam int                     DRAIN_W    = ib_drain_width(PIPELINE_DEPTH);
    localparam logic [DRAIN_W-1:0]     DRAIN_LOAD = DRAIN_W'(PIPELINE_DEPTH - 2);
    localparam logic [ITER_WIDTH-1:0]  ITER_LAST  = ITER_WIDTH'(ITER_MAX - 1);
    localparam logic [LAYER_WIDTH-1:0] LAYER_LAST = LAYER_WIDTH'(LAYER_NUM - 1);
    localparam logic                   SINGLE_IT  = (ITER_MAX == 1);

    ib_ctrl_state_t         r_state;
    logic                   r_v2c_src;
    logic                   r_pipe_en;
    logic                   r_dec_en;
    logic [ITER_WIDTH-1:0]  r_iter_cnt;
    logic [LAYER_WIDTH-1:0] r_layer_cnt;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_layer_phase;
    logic                   w_wrap;
    logic                   w_early;
    logic                   w_finish;
    logic                   w_drain_dec;
    logic                   w_drain_zero;
    logic [ITER_WIDTH-1:0]  w_iter_next;

    // Layer processing happens in FIRST_ITER and ITER; a layer_done on the last
    // layer wraps the layer counter and closes the iteration.
    assign w_layer_phase = (r_state == ST_FIRST_ITER) || (r_state == ST_ITER);
    assign w_wrap        = w_layer_phase && layer_done && (r_layer_cnt == LAYER_LAST);
    assign w_iter_next   = r_iter_cnt + ITER_WIDTH'(1);

`ifdef IB_EARLY_TERM_EN
    // Convergence is only trusted once VNU outputs are in use, i.e. not during
    // the channel-LLR bypass iteration.
    assign w_early = (r_state == ST_ITER) && converged;
`else
    // Port kept for a uniform interface; gated off so only ITER_MAX terminates.
    assign w_early = converged & 1'b0;
`endif

    assign w_finish    = w_wrap && ((r_iter_cnt == ITER_LAST) || w_early);
    assign w_drain_dec = (r_state == ST_DRAIN);

    // Drain length counter, loaded on the edge that enters DRAIN
    ib_drain_counter #(
        .CNT_W (DRAIN_W)
    ) u_drain_cnt (
        .i_clk      (read_clk),
        .i_rst      (reset),
        .i_load     (w_finish),
        .i_load_val (DRAIN_LOAD),
        .i_dec      (w_drain_dec),
        .o_zero     (w_drain_zero)
    );

    // Sequencer FSM with registered outputs
    always_ff @(posedge read_clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_v2c_src   <= 1'b0;
            r_pipe_en   <= 1'b0;
            r_dec_en    <= 1'b0;
            r_iter_cnt  <= '0;
            r_layer_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // start takes priority; a coincident layer_done is dropped
                    if (start) begin
                        r_state     <= ST_FIRST_ITER;
                        r_v2c_src   <= 1'b1;
                        r_pipe_en   <= 1'b1;
                        r_dec_en    <= SINGLE_IT;
                        r_iter_cnt  <= '0;
                        r_layer_cnt <= '0;
                        r_busy      <= 1'b1;
                    end
                end

                ST_FIRST_ITER, ST_ITER: begin
                    if (layer_done) begin
                        if (r_layer_cnt != LAYER_LAST) begin
                            r_layer_cnt <= r_layer_cnt + LAYER_WIDTH'(1);
                        end else begin
                            r_layer_cnt <= '0;
                            r_v2c_src   <= 1'b0;
                            if (w_finish) begin
                                // Iteration counter holds the final value
                                // through DRAIN/DONE for the host to read.
                                r_state  <= ST_DRAIN;
                                r_dec_en <= 1'b1;
                            end else begin
                                r_state    <= ST_ITER;
                                r_iter_cnt <= w_iter_next;
                                r_dec_en   <= (w_iter_next == ITER_LAST);
                            end
                        end
                    end
                end

                ST_DRAIN: begin
                    // Pipeline keeps advancing and decisions keep being
                    // captured until the last in-flight layer leaves.
                    if (w_drain_zero) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_pipe_en <= 1'b0;
                        r_dec_en  <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_v2c_src <= 1'b0;
                    r_pipe_en <= 1'b0;
                    r_dec_en  <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign v2c_src   = r_v2c_src;
    assign pipe_en   = r_pipe_en;
    assign dec_en    = r_dec_en;
    assign iter_cnt  = r_iter_cnt;
    assign layer_cnt = r_layer_cnt;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
